// File: rtl/tone_spkr_gen.sv
// Tone generator: turns a requested frequency in Hz into a square wave on the speaker pin.
// The half-period comes from a sequential restoring divider and is applied only at waveform edges.
module tone_spkr_gen #(
   parameter int unsigned CLK_HZ   = 50000000,
   parameter int unsigned MIN_FREQ = 20,
   parameter int unsigned MAX_FREQ = 20000
) (
   input  logic        FPGA_CLK1_50,
   input  logic        reset_n,
   input  logic [31:0] desiredFrequency,
   output logic        spkr,
   output logic        busy,
   output logic        playing,
   output logic [31:0] half_period
);

   typedef enum logic [1:0] {IDLE, DIV, PEND} state_t;

   state_t      state;
   logic [31:0] last_req;
   logic [31:0] target;
   logic [31:0] count;
   logic [31:0] quo;
   logic [16:0] divisor;
   logic [17:0] rem;
   logic [4:0]  div_cnt;

   logic        change;
   logic        in_range;
   logic        apply;
   logic [17:0] trial;
   logic        fits;

   always_comb begin
      change   = (desiredFrequency != last_req);
      in_range = (desiredFrequency >= 32'(MIN_FREQ)) && (desiredFrequency <= 32'(MAX_FREQ));
      trial    = {rem[16:0], quo[31]};
      fits     = (trial >= {1'b0, divisor});
      // A fresh request in the same cycle discards whatever target is pending.
      apply    = (state == PEND) && !change && ((half_period == '0) || (count == '0));
   end

   assign busy    = (state != IDLE);
   assign playing = (half_period != '0);

   always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_req    <= '0;
         target      <= '0;
         count       <= '0;
         quo         <= '0;
         divisor     <= '0;
         rem         <= '0;
         div_cnt     <= '0;
         spkr        <= 1'b0;
         half_period <= '0;
      end else begin
         last_req <= desiredFrequency;

         if (apply) begin
            half_period <= target;
            if (target == '0) begin
               spkr  <= 1'b0;
               count <= '0;
            end else begin
               // From mute the wave starts high; otherwise this is a normal edge.
               spkr  <= (half_period == '0) ? 1'b1 : ~spkr;
               count <= target - 32'd1;
            end
         end else if (half_period != '0) begin
            if (count == '0) begin
               spkr  <= ~spkr;
               count <= half_period - 32'd1;
            end else begin
               count <= count - 32'd1;
            end
         end

         if (change) begin
            if (!in_range) begin
               target <= '0;
               state  <= PEND;
            end else begin
               quo     <= 32'(CLK_HZ);
               rem     <= '0;
               divisor <= {desiredFrequency[15:0], 1'b0};
               div_cnt <= '0;
               state   <= DIV;
            end
         end else begin
            case (state)
               DIV: begin
                  rem     <= fits ? (trial - {1'b0, divisor}) : trial;
                  quo     <= {quo[30:0], fits};
                  div_cnt <= div_cnt + 5'd1;
                  if (div_cnt == 5'd31) begin
                     target <= {quo[30:0], fits};
                     state  <= PEND;
                  end
               end
               PEND: begin
                  if (apply) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tone_spkr_gen.sv
// Self-checking bench for tone_spkr_gen against an arithmetic model of the tone rules.
// The clock parameter is scaled down 10x so full waveform periods fit in a short run.
module tb_tone_spkr_gen;

   localparam int unsigned CLK_HZ   = 5000000;
   localparam int unsigned MIN_FREQ = 20;
   localparam int unsigned MAX_FREQ = 20000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] freq;
   logic        spkr;
   logic        busy;
   logic        playing;
   logic [31:0] half_period;

   int checks = 0;
   int fails  = 0;

   tone_spkr_gen #(
      .CLK_HZ  (CLK_HZ),
      .MIN_FREQ(MIN_FREQ),
      .MAX_FREQ(MAX_FREQ)
   ) dut (
      .FPGA_CLK1_50    (clk),
      .reset_n         (rst_n),
      .desiredFrequency(freq),
      .spkr            (spkr),
      .busy            (busy),
      .playing         (playing),
      .half_period     (half_period)
   );

   always #5 clk = ~clk;

   function automatic int unsigned model_half(input int unsigned f);
      if (f < MIN_FREQ || f > MAX_FREQ) return 0;
      return CLK_HZ / (2 * f);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles until busy drops, starting from the cycle a new request is driven.
   task automatic busy_len(input int limit, output int n);
      n = 0;
      tick();
      while (busy === 1'b1 && n < limit) begin
         n++;
         tick();
      end
   endtask

   // Cycles spkr stays at the given level, starting from its first cycle at that level.
   task automatic run_len(input logic level, input int limit, output int n);
      n = 0;
      while (spkr === level && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      freq  = '0;
      #2;
      checks++;
      if ({spkr, busy, playing, half_period} !== 35'd0) begin
         fails++;
         $display("FAIL reset_state: got spkr=%b busy=%b playing=%b half=%0d, want all 0", spkr, busy, playing, half_period);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_tone_440();
      int n;
      int unsigned h;
      h = model_half(440);
      freq = 440;
      busy_len(200, n);
      checks++;
      if (n != 33) begin fails++; $display("FAIL busy_440: got %0d cycles, want 33", n); end
      checks++;
      if (half_period !== h) begin fails++; $display("FAIL half_440: got %0d, want %0d", half_period, h); end
      checks++;
      if (spkr !== 1'b1 || playing !== 1'b1) begin
         fails++; $display("FAIL start_440: got spkr=%b playing=%b, want 1 1", spkr, playing);
      end
      run_len(1'b1, 20000, n);
      checks++;
      if (n != int'(h)) begin fails++; $display("FAIL high_440: got %0d, want %0d", n, h); end
      run_len(1'b0, 20000, n);
      checks++;
      if (n != int'(h)) begin fails++; $display("FAIL low_440: got %0d, want %0d", n, h); end
   endtask

   task automatic test_change_1000();
      int n;
      int unsigned h_old, h_new;
      h_old = model_half(440);
      h_new = model_half(1000);
      freq = 1000;
      repeat (40) tick();
      checks++;
      if (half_period !== h_old || busy !== 1'b1) begin
         fails++; $display("FAIL hold_old: got half=%0d busy=%b, want %0d 1", half_period, busy, h_old);
      end
      run_len(1'b1, 20000, n);
      checks++;
      if (n + 40 != int'(h_old)) begin fails++; $display("FAIL no_runt: got %0d, want %0d", n + 40, h_old); end
      checks++;
      if (half_period !== h_new || spkr !== 1'b0) begin
         fails++; $display("FAIL switch_1000: got half=%0d spkr=%b, want %0d 0", half_period, spkr, h_new);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         run_len(spkr, 20000, n);
         checks++;
         if (n != int'(h_new)) begin fails++; $display("FAIL phase_1000: got %0d, want %0d", n, h_new); end
      end
   endtask

   task automatic test_mute();
      int n;
      int highs;
      freq = 0;
      run_len(1'b1, 20000, n);
      checks++;
      if (n != int'(model_half(1000))) begin fails++; $display("FAIL mute_finish: got %0d, want %0d", n, model_half(1000)); end
      checks++;
      if (half_period !== 32'd0 || playing !== 1'b0 || spkr !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mute_state: got half=%0d playing=%b spkr=%b busy=%b, want all 0", half_period, playing, spkr, busy);
      end
      highs = 0;
      for (int unsigned i = 0; i < 1000; i++) begin
         tick();
         if (spkr !== 1'b0) highs++;
      end
      checks++;
      if (highs != 0) begin fails++; $display("FAIL mute_hold: got %0d high cycles, want 0", highs); end
   endtask

   task automatic test_out_of_range();
      int n;
      int unsigned bad [4] = '{25000, 5, 20001, 19};
      foreach (bad[i]) begin
         freq = bad[i];
         busy_len(200, n);
         checks++;
         if (n != 1 || half_period !== 32'd0 || spkr !== 1'b0) begin
            fails++;
            $display("FAIL range_%0d: got busy=%0d half=%0d spkr=%b, want 1 0 0", bad[i], n, half_period, spkr);
         end
      end
      freq = MAX_FREQ;
      busy_len(200, n);
      checks++;
      if (n != 33 || half_period !== model_half(MAX_FREQ)) begin
         fails++; $display("FAIL max_freq: got busy=%0d half=%0d, want 33 %0d", n, half_period, model_half(MAX_FREQ));
      end
      freq = 0;
      busy_len(1000, n);
   endtask

   task automatic test_abort();
      int n;
      freq = 440;
      repeat (10) tick();
      freq = 494;
      busy_len(200, n);
      checks++;
      if (n != 33 || half_period !== model_half(494)) begin
         fails++; $display("FAIL abort: got busy=%0d half=%0d, want 33 %0d", n, half_period, model_half(494));
      end
      freq = 0;
      busy_len(20000, n);
      checks++;
      if (half_period !== 32'd0) begin fails++; $display("FAIL abort_mute: got %0d, want 0", half_period); end
   endtask

   task automatic test_random();
      int n;
      int unsigned f, h;
      for (int unsigned k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0)
            f = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 19) : $urandom_range(20001, 200000);
         else
            f = $urandom_range(1250, 20000);
         h = model_half(f);
         freq = f;
         busy_len(200, n);
         checks++;
         if (n != ((h != 0) ? 33 : 1) || half_period !== h) begin
            fails++; $display("FAIL rand_%0d: got busy=%0d half=%0d, want half %0d", f, n, half_period, h);
         end
         if (h != 0) begin
            run_len(1'b1, 5000, n);
            checks++;
            if (n != int'(h)) begin fails++; $display("FAIL rand_high_%0d: got %0d, want %0d", f, n, h); end
         end
         freq = 0;
         busy_len(5000, n);
         checks++;
         if (half_period !== 32'd0 || spkr !== 1'b0) begin
            fails++; $display("FAIL rand_mute_%0d: got half=%0d spkr=%b, want 0 0", f, half_period, spkr);
         end
      end
   endtask

   task automatic test_same_value();
      int n;
      int busy_hits;
      freq = 1000;
      busy_len(200, n);
      busy_hits = 0;
      for (int unsigned i = 0; i < 50; i++) begin
         freq = 1000;
         tick();
         if (busy !== 1'b0) busy_hits++;
      end
      checks++;
      if (busy_hits != 0 || half_period !== model_half(1000)) begin
         fails++; $display("FAIL same_value: got busy cycles=%0d half=%0d, want 0 %0d", busy_hits, half_period, model_half(1000));
      end
      freq = 0;
      busy_len(5000, n);
   endtask

   task automatic test_min_and_reset_mid_tone();
      int n;
      freq = MIN_FREQ;
      busy_len(200, n);
      checks++;
      if (n != 33 || half_period !== model_half(MIN_FREQ)) begin
         fails++; $display("FAIL min_freq: got busy=%0d half=%0d, want 33 %0d", n, half_period, model_half(MIN_FREQ));
      end
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({spkr, busy, playing, half_period} !== 35'd0) begin
         fails++;
         $display("FAIL reset_tone: got spkr=%b busy=%b playing=%b half=%0d, want all 0", spkr, busy, playing, half_period);
      end
      freq = 0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_div();
      int n;
      freq = 494;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL div_busy: got %b, want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({spkr, busy, playing, half_period} !== 35'd0) begin
         fails++;
         $display("FAIL reset_div: got spkr=%b busy=%b playing=%b half=%0d, want all 0", spkr, busy, playing, half_period);
      end
      freq = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      freq = 494;
      busy_len(200, n);
      checks++;
      if (n != 33 || half_period !== model_half(494) || spkr !== 1'b1) begin
         fails++; $display("FAIL recompute: got busy=%0d half=%0d spkr=%b, want 33 %0d 1", n, half_period, spkr, model_half(494));
      end
   endtask

   initial begin
      test_reset();
      test_tone_440();
      test_change_1000();
      test_mute();
      test_out_of_range();
      test_abort();
      test_random();
      test_same_value();
      test_min_and_reset_mid_tone();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
